// File: rtl/pixel_compositor.sv
// pixel_compositor: registered, layered RGB444 compositor for the VGA path.
// It draws, from highest to lowest priority: blanking, the mouse cursor, the
// target layers and a split-screen background. Each screen half has its own
// click-feedback flash tint, held for FLASH_FRAMES frames.
// Ports:
//   clk, rst             pixel clock, synchronous active-high reset
//   h_cnt, valid         current horizontal pixel, active-video flag
//   frame_start          one-cycle pulse at the start of each frame
//   mouse_x              cursor X, used to pick which half a left click flashes
//   mouse_left/right     button levels (edge detected internally)
//   enable_mouse_display current pixel is a cursor pixel; mouse_pixel = its colour
//   enable_target        per-target hit flags; target_color = packed RGB444 per target
//   vga_red/green/blue   registered RGB444 output
//   flash_active         {right, left} flash state
module pixel_compositor #(
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned NUM_TARGETS   = 4,
  parameter int unsigned FLASH_FRAMES  = 8,
  parameter logic [11:0] BG_COLOR      = 12'hfff,
  parameter logic [11:0] FLASH_COLOR_L = 12'hf5f,
  parameter logic [11:0] FLASH_COLOR_R = 12'h5ff
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [9:0]                h_cnt,
  input  logic                      valid,
  input  logic                      frame_start,
  input  logic [9:0]                mouse_x,
  input  logic                      mouse_left,
  input  logic                      mouse_right,
  input  logic                      enable_mouse_display,
  input  logic [11:0]               mouse_pixel,
  input  logic [NUM_TARGETS-1:0]    enable_target,
  input  logic [12*NUM_TARGETS-1:0] target_color,
  output logic [3:0]                vga_red,
  output logic [3:0]                vga_green,
  output logic [3:0]                vga_blue,
  output logic [1:0]                flash_active
);

  localparam int unsigned CW       = 12;
  localparam logic [10:0] L_HALF   = 11'(H_ACTIVE / 2);
  localparam logic [10:0] L_END    = 11'(H_ACTIVE);
  localparam logic [7:0]  L_FRAMES = 8'(FLASH_FRAMES);

  typedef enum logic {S_IDLE = 1'b0, S_FLASH = 1'b1} state_t;

  logic          r_left_lvl, r_left_prev, r_right_lvl, r_right_prev;
  logic          w_left_rise, w_right_rise;
  logic [10:0]   w_mouse_x, w_h_cnt;
  logic [1:0]    w_trig;
  state_t        r_state [2];
  state_t        w_state_nxt [2];
  logic [7:0]    r_cnt [2];
  logic [7:0]    w_cnt_nxt [2];
  logic [1:0]    w_flash;
  logic          w_tgt_hit;
  logic [CW-1:0] w_tgt_rgb;
  logic [CW-1:0] w_rgb;
  logic [CW-1:0] r_rgb;

  // Button edge detect: the level is registered first, so a rise is seen one
  // cycle after the button is sampled high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_left_lvl   <= 1'b0;
      r_left_prev  <= 1'b0;
      r_right_lvl  <= 1'b0;
      r_right_prev <= 1'b0;
    end else begin
      r_left_lvl   <= mouse_left;
      r_left_prev  <= r_left_lvl;
      r_right_lvl  <= mouse_right;
      r_right_prev <= r_right_lvl;
    end
  end

  assign w_left_rise  = r_left_lvl & ~r_left_prev;
  assign w_right_rise = r_right_lvl & ~r_right_prev;
  assign w_mouse_x    = {1'b0, mouse_x};
  assign w_h_cnt      = {1'b0, h_cnt};

  // Left click flashes the half under the cursor; right click flashes both.
  assign w_trig[0] = w_right_rise | (w_left_rise & (w_mouse_x < L_HALF));
  assign w_trig[1] = w_right_rise |
                     (w_left_rise & (w_mouse_x >= L_HALF) & (w_mouse_x < L_END));

  // Flash FSM state register (index 0 = left half, 1 = right half).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
    end
  end

  // Flash FSM next state: a trigger always reloads and beats a coincident
  // frame_start; otherwise frame_start counts the flash down.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      if (w_trig[i]) begin
        w_state_nxt[i] = S_FLASH;
        w_cnt_nxt[i]   = L_FRAMES;
      end else if ((r_state[i] == S_FLASH) && frame_start) begin
        if (r_cnt[i] <= 8'd1) begin
          w_state_nxt[i] = S_IDLE;
          w_cnt_nxt[i]   = 8'd0;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] - 8'd1;
        end
      end
    end
  end

  // Flash FSM outputs.
  always_comb begin
    w_flash = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_flash[i] = (r_state[i] == S_FLASH);
    end
  end

  assign flash_active = w_flash;

  // Lowest-index target wins: scan from the top so lower indices overwrite.
  always_comb begin
    w_tgt_hit = 1'b0;
    w_tgt_rgb = '0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if (enable_target[i]) begin
        w_tgt_hit = 1'b1;
        w_tgt_rgb = target_color[CW*i +: CW];
      end
    end
  end

  // Layer priority for the current pixel.
  always_comb begin
    w_rgb = 12'h000;
    if (!valid) begin
      w_rgb = 12'h000;
    end else if (enable_mouse_display) begin
      w_rgb = mouse_pixel;
    end else if (w_tgt_hit) begin
      w_rgb = w_tgt_rgb;
    end else if (w_h_cnt < L_HALF) begin
      w_rgb = w_flash[0] ? FLASH_COLOR_L : BG_COLOR;
    end else if (w_h_cnt < L_END) begin
      w_rgb = w_flash[1] ? FLASH_COLOR_R : BG_COLOR;
    end
  end

  // One-cycle pixel pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= w_rgb;
    end
  end

  assign vga_red   = r_rgb[11:8];
  assign vga_green = r_rgb[7:4];
  assign vga_blue  = r_rgb[3:0];

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed testbench for pixel_compositor with default parameters.
module tb_pixel_compositor;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  h_cnt;
  logic        valid;
  logic        frame_start;
  logic [9:0]  mouse_x;
  logic        mouse_left;
  logic        mouse_right;
  logic        enable_mouse_display;
  logic [11:0] mouse_pixel;
  logic [3:0]  enable_target;
  logic [47:0] target_color;
  logic [3:0]  vga_red, vga_green, vga_blue;
  logic [1:0]  flash_active;
  logic [11:0] rgb;

  int checks = 0;
  int errors = 0;

  pixel_compositor dut (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .valid(valid), .frame_start(frame_start),
    .mouse_x(mouse_x), .mouse_left(mouse_left), .mouse_right(mouse_right),
    .enable_mouse_display(enable_mouse_display), .mouse_pixel(mouse_pixel),
    .enable_target(enable_target), .target_color(target_color),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .flash_active(flash_active)
  );

  always #5 clk = ~clk;

  assign rgb = {vga_red, vga_green, vga_blue};

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic click_left(input logic [9:0] x);
    mouse_x    = x;
    mouse_left = 1'b1;
    tick();
    mouse_left = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid = 1'b1;
    enable_mouse_display = 1'b1;
    mouse_pixel = 12'h123;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb cyc%0d got %h exp 000", c, rgb); end
      checks++;
      if (flash_active !== 2'b00) begin errors++; $display("FAIL reset_flash cyc%0d got %b exp 00", c, flash_active); end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (rgb !== 12'h123) begin errors++; $display("FAIL reset_first_pixel got %h exp 123", rgb); end
  endtask

  task automatic test_priority();
    h_cnt = 10'd100;
    valid = 1'b1;
    enable_mouse_display = 1'b1;
    mouse_pixel = 12'habc;
    enable_target = 4'b0110;
    tick();
    checks++;
    if (rgb !== 12'habc) begin errors++; $display("FAIL prio_mouse got %h exp abc", rgb); end
    enable_mouse_display = 1'b0;
    tick();
    checks++;
    if (rgb !== 12'h0f0) begin errors++; $display("FAIL prio_target1 got %h exp 0f0", rgb); end
    enable_target = 4'b1100;
    tick();
    checks++;
    if (rgb !== 12'h00f) begin errors++; $display("FAIL prio_target2 got %h exp 00f", rgb); end
    enable_target = 4'b0000;
    tick();
    checks++;
    if (rgb !== 12'hfff) begin errors++; $display("FAIL prio_bg got %h exp fff", rgb); end
    valid = 1'b0;
    tick();
    checks++;
    if (rgb !== 12'h000) begin errors++; $display("FAIL prio_blank got %h exp 000", rgb); end
    valid = 1'b1;
  endtask

  task automatic test_left_flash();
    click_left(10'd100);
    checks++;
    if (flash_active !== 2'b01) begin errors++; $display("FAIL lflash_state got %b exp 01", flash_active); end
    h_cnt = 10'd50;
    tick();
    checks++;
    if (rgb !== 12'hf5f) begin errors++; $display("FAIL lflash_left_px got %h exp f5f", rgb); end
    h_cnt = 10'd400;
    tick();
    checks++;
    if (rgb !== 12'hfff) begin errors++; $display("FAIL lflash_right_px got %h exp fff", rgb); end
    for (int f = 0; f < 7; f++) frame();
    checks++;
    if (flash_active !== 2'b01) begin errors++; $display("FAIL lflash_7frames got %b exp 01", flash_active); end
    frame();
    checks++;
    if (flash_active !== 2'b00) begin errors++; $display("FAIL lflash_8frames got %b exp 00", flash_active); end
    h_cnt = 10'd50;
    tick();
    checks++;
    if (rgb !== 12'hfff) begin errors++; $display("FAIL lflash_end_px got %h exp fff", rgb); end
  endtask

  task automatic test_right_button();
    mouse_right = 1'b1;
    tick();
    tick();
    checks++;
    if (flash_active !== 2'b11) begin errors++; $display("FAIL rbtn_state got %b exp 11", flash_active); end
    h_cnt = 10'd400;
    tick();
    checks++;
    if (rgb !== 12'h5ff) begin errors++; $display("FAIL rbtn_right_px got %h exp 5ff", rgb); end
    for (int f = 0; f < 7; f++) frame();
    checks++;
    if (flash_active !== 2'b11) begin errors++; $display("FAIL rbtn_7frames got %b exp 11", flash_active); end
    frame();
    checks++;
    if (flash_active !== 2'b00) begin errors++; $display("FAIL rbtn_8frames got %b exp 00", flash_active); end
    for (int f = 0; f < 12; f++) frame();
    checks++;
    if (flash_active !== 2'b00) begin errors++; $display("FAIL rbtn_held got %b exp 00", flash_active); end
    mouse_right = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_retrigger();
    click_left(10'd100);
    for (int f = 0; f < 5; f++) frame();
    checks++;
    if (flash_active !== 2'b01) begin errors++; $display("FAIL retrig_5frames got %b exp 01", flash_active); end
    // Rise becomes visible to the FSM on the cycle frame_start is high.
    mouse_left = 1'b1;
    tick();
    mouse_left = 1'b0;
    frame();
    for (int f = 0; f < 7; f++) frame();
    checks++;
    if (flash_active !== 2'b01) begin errors++; $display("FAIL retrig_extend got %b exp 01", flash_active); end
    frame();
    checks++;
    if (flash_active !== 2'b00) begin errors++; $display("FAIL retrig_end got %b exp 00", flash_active); end
  endtask

  task automatic test_boundaries();
    click_left(10'd319);
    checks++;
    if (flash_active !== 2'b01) begin errors++; $display("FAIL bnd_x319 got %b exp 01", flash_active); end
    do_reset();
    click_left(10'd700);
    checks++;
    if (flash_active !== 2'b00) begin errors++; $display("FAIL bnd_x700 got %b exp 00", flash_active); end
    click_left(10'd320);
    checks++;
    if (flash_active !== 2'b10) begin errors++; $display("FAIL bnd_x320 got %b exp 10", flash_active); end
    h_cnt = 10'd639;
    tick();
    checks++;
    if (rgb !== 12'h5ff) begin errors++; $display("FAIL bnd_h639 got %h exp 5ff", rgb); end
    h_cnt = 10'd320;
    tick();
    checks++;
    if (rgb !== 12'h5ff) begin errors++; $display("FAIL bnd_h320 got %h exp 5ff", rgb); end
    h_cnt = 10'd319;
    tick();
    checks++;
    if (rgb !== 12'hfff) begin errors++; $display("FAIL bnd_h319 got %h exp fff", rgb); end
    h_cnt = 10'd640;
    tick();
    checks++;
    if (rgb !== 12'h000) begin errors++; $display("FAIL bnd_h640 got %h exp 000", rgb); end
    // Reset mid-flash drops the flash at once.
    do_reset();
    checks++;
    if (flash_active !== 2'b00) begin errors++; $display("FAIL bnd_reset_abort got %b exp 00", flash_active); end
  endtask

  initial begin
    rst = 1'b1;
    h_cnt = 10'd100;
    valid = 1'b1;
    frame_start = 1'b0;
    mouse_x = 10'd0;
    mouse_left = 1'b0;
    mouse_right = 1'b0;
    enable_mouse_display = 1'b0;
    mouse_pixel = 12'h000;
    enable_target = 4'b0000;
    target_color = {12'hff0, 12'h00f, 12'h0f0, 12'hf00};
    #1;
    test_reset();
    enable_mouse_display = 1'b0;
    test_priority();
    test_left_flash();
    test_right_button();
    test_retrigger();
    test_boundaries();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
